// File: rtl/order_book_levels_pkg.sv
// Shared types and sizing for the price-level order book.
package order_book_levels_pkg;

    localparam int unsigned NUM_SYMBOLS = 4;
    localparam int unsigned LEVELS      = 8;
    localparam int unsigned PRICE_W     = 32;
    localparam int unsigned SHARES_W    = 32;
    localparam int unsigned LOC_W       = 16;
    localparam int unsigned SYM_W       = $clog2(NUM_SYMBOLS);
    localparam int unsigned CNT_W       = 32;

    typedef struct packed {
        logic [PRICE_W-1:0]  price;
        logic [SHARES_W-1:0] shares;
        logic                used;
    } level_t;

    typedef level_t [LEVELS-1:0] side_t;

    typedef enum logic {
        SIDE_ASK = 1'b0,
        SIDE_BID = 1'b1
    } side_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_DEL = 1'b1
    } op_e;

    typedef struct packed {
        logic [LOC_W-1:0]    locate;
        logic [PRICE_W-1:0]  price;
        logic [SHARES_W-1:0] shares;
        side_e               side;
    } msg_t;

    // Bids rank higher prices first, asks rank lower prices first.
    function automatic logic price_better(input side_e side,
                                          input logic [PRICE_W-1:0] a,
                                          input logic [PRICE_W-1:0] b);
        return (side == SIDE_BID) ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/order_book_levels_book_side_update.sv
// Combinational add/delete applied to one sorted side of one symbol's book.
module book_side_update
    import order_book_levels_pkg::*;
(
    input  side_t               lvl_i,
    input  side_e               side_i,
    input  op_e                 op_i,
    input  logic [PRICE_W-1:0]  price_i,
    input  logic [SHARES_W-1:0] shares_i,
    output side_t               lvl_o,
    output logic                changed_o,
    output logic                drop_o,
    output logic                evict_o,
    output logic                miss_o,
    output logic                underflow_o
);

    logic                hit;
    logic                ins_found;
    int unsigned         hit_idx;
    int unsigned         ins_idx;
    logic [SHARES_W-1:0] hit_shares;
    logic [SHARES_W:0]   sum;
    level_t              new_lvl;

    always_comb begin
        hit        = 1'b0;
        hit_idx    = 0;
        hit_shares = '0;
        ins_found  = 1'b0;
        ins_idx    = 0;
        for (int unsigned i = 0; i < LEVELS; i++) begin
            if (!hit && lvl_i[i].used && (lvl_i[i].price == price_i)) begin
                hit        = 1'b1;
                hit_idx    = i;
                hit_shares = lvl_i[i].shares;
            end
            if (!ins_found && (!lvl_i[i].used || price_better(side_i, price_i, lvl_i[i].price))) begin
                ins_found = 1'b1;
                ins_idx   = i;
            end
        end
    end

    always_comb begin
        lvl_o          = lvl_i;
        changed_o      = 1'b0;
        drop_o         = 1'b0;
        evict_o        = 1'b0;
        miss_o         = 1'b0;
        underflow_o    = 1'b0;
        sum            = {1'b0, hit_shares} + {1'b0, shares_i};
        new_lvl.price  = price_i;
        new_lvl.shares = shares_i;
        new_lvl.used   = 1'b1;

        if (op_i == OP_ADD) begin
            if (hit) begin
                changed_o = 1'b1;
                for (int unsigned i = 0; i < LEVELS; i++) begin
                    if (i == hit_idx) lvl_o[i].shares = sum[SHARES_W] ? '1 : sum[SHARES_W-1:0];
                end
            end else if (!ins_found) begin
                drop_o = 1'b1;
            end else begin
                changed_o = 1'b1;
                evict_o   = lvl_i[LEVELS-1].used;
                if (ins_idx == 0) lvl_o[0] = new_lvl;
                for (int unsigned i = 1; i < LEVELS; i++) begin
                    if (i == ins_idx)     lvl_o[i] = new_lvl;
                    else if (i > ins_idx) lvl_o[i] = lvl_i[i-1];
                end
            end
        end else begin
            if (!hit) begin
                miss_o = 1'b1;
            end else if (shares_i >= hit_shares) begin
                // Level emptied: close the gap so used entries stay contiguous.
                changed_o   = 1'b1;
                underflow_o = (shares_i > hit_shares);
                for (int unsigned i = 0; i < LEVELS - 1; i++) begin
                    if (i >= hit_idx) lvl_o[i] = lvl_i[i+1];
                end
                lvl_o[LEVELS-1] = '0;
            end else begin
                changed_o = 1'b1;
                for (int unsigned i = 0; i < LEVELS; i++) begin
                    if (i == hit_idx) lvl_o[i].shares = hit_shares - shares_i;
                end
            end
        end
    end

endmodule

// File: rtl/order_book_levels.sv
// Per-symbol price-level bid/ask books with a registered top-of-book pulse.
// ORDER_BOOK_STATS_EN adds saturating drop/evict/miss/underflow counters.
module order_book_levels
    import order_book_levels_pkg::*;
(
    input  logic                clkIn,
    input  logic                rstIn,
    input  logic                addValidIn,
    input  logic                delExecValidIn,
    input  logic [LOC_W-1:0]    locateIn,
    input  logic [PRICE_W-1:0]  priceIn,
    input  logic [SHARES_W-1:0] sharesIn,
    input  logic                buySellIn,
    input  logic [LOC_W-1:0]    mapLocateIn,
    input  logic [PRICE_W-1:0]  mapPriceIn,
    input  logic [SHARES_W-1:0] mapSharesIn,
    input  logic                mapBuySellIn,
    output logic                readyOut,
    output logic                tobValidOut,
    output logic [LOC_W-1:0]    tobLocateOut,
    output logic [PRICE_W-1:0]  tobBidPriceOut,
    output logic [SHARES_W-1:0] tobBidSharesOut,
    output logic [PRICE_W-1:0]  tobAskPriceOut,
    output logic [SHARES_W-1:0] tobAskSharesOut
`ifdef ORDER_BOOK_STATS_EN
    ,
    output logic [CNT_W-1:0]    dropCntOut,
    output logic [CNT_W-1:0]    evictCntOut,
    output logic [CNT_W-1:0]    missCntOut,
    output logic [CNT_W-1:0]    underflowCntOut
`endif
);

    side_t               book_q [NUM_SYMBOLS][2];
    side_t               book_d [NUM_SYMBOLS][2];
    msg_t                pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;
    logic                tob_valid_q, tob_valid_d;
    logic [LOC_W-1:0]    tob_loc_q, tob_loc_d;
    logic [PRICE_W-1:0]  tob_bid_p_q, tob_bid_p_d, tob_ask_p_q, tob_ask_p_d;
    logic [SHARES_W-1:0] tob_bid_s_q, tob_bid_s_d, tob_ask_s_q, tob_ask_s_d;

    msg_t             add_msg, del_msg, cur_msg;
    op_e              cur_op;
    logic             cur_valid, loc_ok, apply;
    logic [SYM_W-1:0] sym;
    side_t            cur_lvl, upd_lvl;
    level_t           bid_best, ask_best;
    logic             changed, drop, evict, miss, underflow;

    assign add_msg = '{locate: locateIn, price: priceIn, shares: sharesIn, side: side_e'(buySellIn)};
    assign del_msg = '{locate: mapLocateIn, price: mapPriceIn, shares: mapSharesIn, side: side_e'(mapBuySellIn)};

    // A parked add always wins the next cycle; the source holds valids low meanwhile.
    always_comb begin
        pend_valid_d = 1'b0;
        pend_d       = pend_q;
        cur_valid    = 1'b0;
        cur_op       = OP_ADD;
        cur_msg      = add_msg;
        if (pend_valid_q) begin
            cur_valid = 1'b1;
            cur_msg   = pend_q;
        end else if (delExecValidIn) begin
            cur_valid = 1'b1;
            cur_op    = OP_DEL;
            cur_msg   = del_msg;
            if (addValidIn) begin
                pend_valid_d = 1'b1;
                pend_d       = add_msg;
            end
        end else if (addValidIn) begin
            cur_valid = 1'b1;
        end
    end

    assign loc_ok  = (cur_msg.locate < LOC_W'(NUM_SYMBOLS));
    assign sym     = cur_msg.locate[SYM_W-1:0];
    assign cur_lvl = book_q[sym][cur_msg.side];
    assign apply   = cur_valid && loc_ok && changed;

    book_side_update u_update (
        .lvl_i       (cur_lvl),
        .side_i      (cur_msg.side),
        .op_i        (cur_op),
        .price_i     (cur_msg.price),
        .shares_i    (cur_msg.shares),
        .lvl_o       (upd_lvl),
        .changed_o   (changed),
        .drop_o      (drop),
        .evict_o     (evict),
        .miss_o      (miss),
        .underflow_o (underflow)
    );

    always_comb begin
        book_d = book_q;
        if (apply) book_d[sym][cur_msg.side] = upd_lvl;

        bid_best = (cur_msg.side == SIDE_BID) ? upd_lvl[0] : book_q[sym][SIDE_BID][0];
        ask_best = (cur_msg.side == SIDE_ASK) ? upd_lvl[0] : book_q[sym][SIDE_ASK][0];

        tob_valid_d = apply;
        tob_loc_d   = tob_loc_q;
        tob_bid_p_d = tob_bid_p_q;
        tob_bid_s_d = tob_bid_s_q;
        tob_ask_p_d = tob_ask_p_q;
        tob_ask_s_d = tob_ask_s_q;
        if (apply) begin
            tob_loc_d   = cur_msg.locate;
            tob_bid_p_d = bid_best.used ? bid_best.price  : '0;
            tob_bid_s_d = bid_best.used ? bid_best.shares : '0;
            tob_ask_p_d = ask_best.used ? ask_best.price  : '0;
            tob_ask_s_d = ask_best.used ? ask_best.shares : '0;
        end
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            for (int unsigned s = 0; s < NUM_SYMBOLS; s++) begin
                for (int unsigned d = 0; d < 2; d++) begin
                    book_q[s][d] <= '0;
                end
            end
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            tob_valid_q  <= 1'b0;
            tob_loc_q    <= '0;
            tob_bid_p_q  <= '0;
            tob_bid_s_q  <= '0;
            tob_ask_p_q  <= '0;
            tob_ask_s_q  <= '0;
        end else begin
            book_q       <= book_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            tob_valid_q  <= tob_valid_d;
            tob_loc_q    <= tob_loc_d;
            tob_bid_p_q  <= tob_bid_p_d;
            tob_bid_s_q  <= tob_bid_s_d;
            tob_ask_p_q  <= tob_ask_p_d;
            tob_ask_s_q  <= tob_ask_s_d;
        end
    end

    assign readyOut        = !pend_valid_q;
    assign tobValidOut     = tob_valid_q;
    assign tobLocateOut    = tob_loc_q;
    assign tobBidPriceOut  = tob_bid_p_q;
    assign tobBidSharesOut = tob_bid_s_q;
    assign tobAskPriceOut  = tob_ask_p_q;
    assign tobAskSharesOut = tob_ask_s_q;

`ifdef ORDER_BOOK_STATS_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d, evict_cnt_q, evict_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d, under_cnt_q, under_cnt_d;
    logic             ev_ok;

    assign ev_ok = cur_valid && loc_ok;

    always_comb begin
        drop_cnt_d  = drop_cnt_q;
        evict_cnt_d = evict_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        under_cnt_d = under_cnt_q;
        if (ev_ok && drop      && (drop_cnt_q  != '1)) drop_cnt_d  = drop_cnt_q  + 1'b1;
        if (ev_ok && evict     && (evict_cnt_q != '1)) evict_cnt_d = evict_cnt_q + 1'b1;
        if (ev_ok && miss      && (miss_cnt_q  != '1)) miss_cnt_d  = miss_cnt_q  + 1'b1;
        if (ev_ok && underflow && (under_cnt_q != '1)) under_cnt_d = under_cnt_q + 1'b1;
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            drop_cnt_q  <= '0;
            evict_cnt_q <= '0;
            miss_cnt_q  <= '0;
            under_cnt_q <= '0;
        end else begin
            drop_cnt_q  <= drop_cnt_d;
            evict_cnt_q <= evict_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            under_cnt_q <= under_cnt_d;
        end
    end

    assign dropCntOut      = drop_cnt_q;
    assign evictCntOut     = evict_cnt_q;
    assign missCntOut      = miss_cnt_q;
    assign underflowCntOut = under_cnt_q;
`else
    logic unused_event_flags;
    assign unused_event_flags = drop ^ evict ^ miss ^ underflow;
`endif

endmodule

// File: tb/tb_order_book_levels.sv
// Directed vector bench for order_book_levels; optional counter checks follow ORDER_BOOK_STATS_EN.
module tb_order_book_levels;

    logic        clkIn = 1'b0;
    logic        rstIn = 1'b0;
    logic        addValidIn = 1'b0, delExecValidIn = 1'b0;
    logic [15:0] locateIn = '0, mapLocateIn = '0;
    logic [31:0] priceIn = '0, sharesIn = '0, mapPriceIn = '0, mapSharesIn = '0;
    logic        buySellIn = 1'b0, mapBuySellIn = 1'b0;
    logic        readyOut, tobValidOut;
    logic [15:0] tobLocateOut;
    logic [31:0] tobBidPriceOut, tobBidSharesOut, tobAskPriceOut, tobAskSharesOut;
`ifdef ORDER_BOOK_STATS_EN
    logic [31:0] dropCntOut, evictCntOut, missCntOut, underflowCntOut;
`endif

    always #5 clkIn = ~clkIn;

    order_book_levels dut (
        .clkIn           (clkIn),
        .rstIn           (rstIn),
        .addValidIn      (addValidIn),
        .delExecValidIn  (delExecValidIn),
        .locateIn        (locateIn),
        .priceIn         (priceIn),
        .sharesIn        (sharesIn),
        .buySellIn       (buySellIn),
        .mapLocateIn     (mapLocateIn),
        .mapPriceIn      (mapPriceIn),
        .mapSharesIn     (mapSharesIn),
        .mapBuySellIn    (mapBuySellIn),
        .readyOut        (readyOut),
        .tobValidOut     (tobValidOut),
        .tobLocateOut    (tobLocateOut),
        .tobBidPriceOut  (tobBidPriceOut),
        .tobBidSharesOut (tobBidSharesOut),
        .tobAskPriceOut  (tobAskPriceOut),
        .tobAskSharesOut (tobAskSharesOut)
`ifdef ORDER_BOOK_STATS_EN
        ,
        .dropCntOut      (dropCntOut),
        .evictCntOut     (evictCntOut),
        .missCntOut      (missCntOut),
        .underflowCntOut (underflowCntOut)
`endif
    );

    typedef struct {
        logic        is_add;
        logic [15:0] loc;
        logic [31:0] price;
        logic [31:0] shares;
        logic        bid;
        logic        exp_v;
        logic [15:0] exp_loc;
        logic [31:0] ebp, ebs, eap, eas;
    } vec_t;

    vec_t        vecs[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic is_add, input logic [15:0] loc,
                                    input logic [31:0] price, input logic [31:0] shares,
                                    input logic bid, input logic exp_v, input logic [15:0] exp_loc,
                                    input logic [31:0] ebp, input logic [31:0] ebs,
                                    input logic [31:0] eap, input logic [31:0] eas);
        vec_t v;
        v.is_add = is_add; v.loc = loc; v.price = price; v.shares = shares; v.bid = bid;
        v.exp_v = exp_v; v.exp_loc = exp_loc; v.ebp = ebp; v.ebs = ebs; v.eap = eap; v.eas = eas;
        vecs.push_back(v);
    endfunction

    task automatic check_tob(input string tag, input logic ev, input logic [15:0] el,
                             input logic [31:0] ebp, input logic [31:0] ebs,
                             input logic [31:0] eap, input logic [31:0] eas);
        check({tag, ".valid"}, 64'(tobValidOut), 64'(ev));
        if (ev) begin
            check({tag, ".loc"},   64'(tobLocateOut),    64'(el));
            check({tag, ".bidP"},  64'(tobBidPriceOut),  64'(ebp));
            check({tag, ".bidS"},  64'(tobBidSharesOut), 64'(ebs));
            check({tag, ".askP"},  64'(tobAskPriceOut),  64'(eap));
            check({tag, ".askS"},  64'(tobAskSharesOut), 64'(eas));
        end
    endtask

    task automatic set_add(input logic [15:0] loc, input logic [31:0] p, input logic [31:0] s, input logic b);
        locateIn = loc; priceIn = p; sharesIn = s; buySellIn = b; addValidIn = 1'b1;
    endtask

    task automatic set_del(input logic [15:0] loc, input logic [31:0] p, input logic [31:0] s, input logic b);
        mapLocateIn = loc; mapPriceIn = p; mapSharesIn = s; mapBuySellIn = b; delExecValidIn = 1'b1;
    endtask

    task automatic step_and_clear();
        @(posedge clkIn);
        #1;
        addValidIn = 1'b0;
        delExecValidIn = 1'b0;
    endtask

    initial begin
        // locate 0: bid ordering, exact delete, underflow, miss
        add_vec(1, 0, 100, 10, 1,  1, 0, 100, 10, 0, 0);
        add_vec(1, 0, 101,  5, 1,  1, 0, 101,  5, 0, 0);
        add_vec(1, 0,  99,  7, 1,  1, 0, 101,  5, 0, 0);
        add_vec(0, 0, 101,  5, 1,  1, 0, 100, 10, 0, 0);
        add_vec(0, 0, 100, 20, 1,  1, 0,  99,  7, 0, 0);
        add_vec(0, 0, 555,  1, 1,  0, 0,   0,  0, 0, 0);
        // locate 1: ask aggregation and removal
        add_vec(1, 1, 200, 3, 0,  1, 1, 0, 0, 200, 3);
        add_vec(1, 1, 200, 3, 0,  1, 1, 0, 0, 200, 6);
        add_vec(0, 1, 200, 6, 0,  1, 1, 0, 0,   0, 0);
        add_vec(0, 1, 200, 1, 0,  0, 0, 0, 0,   0, 0);
        // locate 2: fill, drop worse, evict with better, then drain to prove eviction
        for (int i = 1; i <= 8; i++) add_vec(1, 2, 32'(i), 1, 1,  1, 2, 32'(i), 1, 0, 0);
        add_vec(1, 2, 0, 1, 1,  0, 0, 0, 0, 0, 0);
        add_vec(1, 2, 9, 1, 1,  1, 2, 9, 1, 0, 0);
        for (int k = 9; k >= 2; k--)
            add_vec(0, 2, 32'(k), 1, 1,  1, 2, (k == 2) ? 32'd0 : 32'(k - 1), (k == 2) ? 32'd0 : 32'd1, 0, 0);
        add_vec(0, 2, 1, 1, 1,  0, 0, 0, 0, 0, 0);
        // locate 3: ascending asks and saturating bid shares
        add_vec(1, 3, 50, 1, 0,  1, 3, 0, 0, 50, 1);
        add_vec(1, 3, 40, 2, 0,  1, 3, 0, 0, 40, 2);
        add_vec(1, 3, 60, 3, 0,  1, 3, 0, 0, 40, 2);
        add_vec(0, 3, 40, 2, 0,  1, 3, 0, 0, 50, 1);
        add_vec(0, 3, 50, 1, 0,  1, 3, 0, 0, 60, 3);
        add_vec(1, 3, 500, 32'hFFFF_FFF0, 1,  1, 3, 500, 32'hFFFF_FFF0, 60, 3);
        add_vec(1, 3, 500, 32'h0000_0020, 1,  1, 3, 500, 32'hFFFF_FFFF, 60, 3);
        add_vec(0, 3, 500, 32'h0000_000F, 1,  1, 3, 500, 32'hFFFF_FFF0, 60, 3);
        // out-of-range locate
        add_vec(1, 7, 5, 5, 1,  0, 0, 0, 0, 0, 0);
        add_vec(0, 7, 5, 5, 1,  0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clkIn);
        check("rst.valid", 64'(tobValidOut), 64'd0);
        check("rst.ready", 64'(readyOut), 64'd1);
        check("rst.bidP",  64'(tobBidPriceOut), 64'd0);
        check("rst.askS",  64'(tobAskSharesOut), 64'd0);
        rstIn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clkIn);
            if (vecs[i].is_add) set_add(vecs[i].loc, vecs[i].price, vecs[i].shares, vecs[i].bid);
            else                set_del(vecs[i].loc, vecs[i].price, vecs[i].shares, vecs[i].bid);
            step_and_clear();
            check_tob($sformatf("v%0d", i), vecs[i].exp_v, vecs[i].exp_loc,
                      vecs[i].ebp, vecs[i].ebs, vecs[i].eap, vecs[i].eas);
        end

`ifdef ORDER_BOOK_STATS_EN
        check("cnt.drop",  64'(dropCntOut),      64'd1);
        check("cnt.evict", 64'(evictCntOut),     64'd1);
        check("cnt.miss",  64'(missCntOut),      64'd3);
        check("cnt.under", 64'(underflowCntOut), 64'd1);
`endif

        // Simultaneous add + delete on locate 0 (bid 99x7 resting)
        @(negedge clkIn);
        check("both.readyBefore", 64'(readyOut), 64'd1);
        set_add(0, 120, 4, 1);
        set_del(0, 99, 2, 1);
        step_and_clear();
        check_tob("both.del", 1, 0, 99, 5, 0, 0);
        check("both.readyLow", 64'(readyOut), 64'd0);
        @(posedge clkIn); #1;
        check_tob("both.add", 1, 0, 120, 4, 0, 0);
        check("both.readyHigh", 64'(readyOut), 64'd1);
        @(posedge clkIn); #1;
        check("both.quiet", 64'(tobValidOut), 64'd0);

        // Reset while an add is parked
        @(negedge clkIn);
        set_add(0, 130, 1, 1);
        set_del(0, 120, 4, 1);
        step_and_clear();
        check_tob("rst2.del", 1, 0, 99, 5, 0, 0);
        check("rst2.readyLow", 64'(readyOut), 64'd0);
        #2 rstIn = 1'b0;
        #1;
        check("rst2.valid", 64'(tobValidOut), 64'd0);
        check("rst2.bidP",  64'(tobBidPriceOut), 64'd0);
        check("rst2.bidS",  64'(tobBidSharesOut), 64'd0);
        check("rst2.ready", 64'(readyOut), 64'd1);
`ifdef ORDER_BOOK_STATS_EN
        check("rst2.cntMiss", 64'(missCntOut), 64'd0);
`endif
        @(negedge clkIn);
        rstIn = 1'b1;
        @(posedge clkIn); #1;
        check("rst2.noPend", 64'(tobValidOut), 64'd0);
        @(negedge clkIn);
        set_add(0, 70, 1, 0);
        step_and_clear();
        check_tob("rst2.fresh", 1, 0, 0, 0, 70, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
